stage_wb_queue: RTL
===================

STAGE_WB_QUEUE -- requirements
Module: stage_wb_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the register address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the pending-writeback entry count; it SHALL be a power of 2 and at least 2.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port rdy_in, input, 1 bit: global ready; 0 = pause.
REQ-007 SHALL have port in_valid_i, input, 1 bit: a writeback request is offered.
REQ-008 SHALL have port in_ready_o, output, 1 bit: the queue accepts a request this cycle.
REQ-009 SHALL have port rd_addr_i, input, ADDR_W bits: destination register.
REQ-010 SHALL have port rd_write_i, input, 1 bit: the request actually writes.
REQ-011 SHALL have port rd_data_i, input, DATA_W bits: write data.
REQ-012 SHALL have port wr_ready_i, input, 1 bit: the register-file port can take a write this cycle.
REQ-013 SHALL have ports rd_addr_o (output, ADDR_W bits), rd_write_o (output, 1 bit) and rd_data_o (output, DATA_W bits): the registered register-file write port.
REQ-014 SHALL have port fwd_addr_i, input, ADDR_W bits: forwarding lookup address.
REQ-015 SHALL have ports fwd_hit_o (output, 1 bit) and fwd_data_o (output, DATA_W bits): the combinational forwarding result.
REQ-016 SHALL have port count_o, output, clog2(DEPTH+1) bits: the number of stored entries.

Function
REQ-017 SHALL hold a circular FIFO with head/tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate count register.
REQ-018 in_ready_o SHALL equal (count_o < DEPTH) && rdy_in && !rst_in, combinationally.
REQ-019 Accept SHALL mean in_valid_i && in_ready_o.
  - An accepted request with rd_write_i=1 and rd_addr_i!=0 SHALL be stored at tail, and tail SHALL increment.
  - An accepted request with rd_write_i=0 or rd_addr_i=0 SHALL be consumed and discarded, with no state change.
REQ-020 Pop SHALL mean rdy_in && wr_ready_i && count_o>0.
  - On pop, the head entry SHALL load rd_addr_o and rd_data_o, and head SHALL increment.
REQ-021 rd_write_o SHALL be registered, and its next value SHALL equal pop; it is therefore a one-cycle pulse per popped entry.
REQ-022 When rd_write_o is low, rd_addr_o and rd_data_o SHALL hold their last values.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged.
  - This includes count=DEPTH-1.
  - At count=DEPTH no push occurs, because in_ready_o is 0.
REQ-024 Latency SHALL be fixed at 2 cycles:
  - a request accepted into an empty queue at edge t is stored;
  - it pops at edge t+1 if wr_ready_i=1;
  - rd_write_o=1 during the cycle after edge t+1.
REQ-025 Entries SHALL drain in strict acceptance order.
REQ-026 With wr_ready_i=0, entries SHALL be held indefinitely without loss or reorder.
REQ-027 With rdy_in=0:
  - no push or pop SHALL occur;
  - pointers, count and data SHALL hold;
  - rd_write_o SHALL be 0 from the next edge on.
REQ-028 fwd_hit_o SHALL be 1 iff fwd_addr_i!=0 and fwd_addr_i matches either a valid stored entry or rd_addr_o while rd_write_o=1.
REQ-029 fwd_data_o SHALL be the data of the youngest match, with this priority:
  - stored entries, youngest first (tail-1 toward head);
  - then the output register.
  - When fwd_hit_o=0, fwd_data_o SHALL be 0.
REQ-030 Forwarding SHALL NOT see the request being offered on rd_*_i in the same cycle.
REQ-031 count_o SHALL reflect the registered count; no combinational path SHALL exist from rd_*_i to count_o.

Reset
REQ-032 On a clock edge with rst_in=1, head, tail and count SHALL become 0, and rd_write_o, rd_addr_o and rd_data_o SHALL become 0, regardless of rdy_in.
REQ-033 Reset mid-operation SHALL discard all pending entries, with no write pulse in the cycle after the reset edge.
REQ-034 During reset, in_ready_o SHALL be 0 and fwd_hit_o SHALL be 0.

Verification
REQ-035 Scenario, single write: one request {rd=5, data=0xDEADBEEF} into an empty queue with wr_ready_i=1 -> rd_write_o=1 for exactly 1 cycle, 2 cycles after accept, with rd_addr_o=5 and rd_data_o=0xDEADBEEF.
REQ-036 Scenario, fill and order:
  - Stimulus: hold wr_ready_i=0 and push 4 requests rd=1..4, data=0x10..0x13.
  - Required response: count_o=4 and in_ready_o=0.
  - Then release wr_ready_i -> 4 consecutive pulses in order rd=1..4, and count_o reaches 0.
REQ-037 Scenario, filtering: push {rd=0, write=1} and {rd=7, write=0} -> both accepted, count_o stays 0, and no rd_write_o pulse.
REQ-038 Scenario, forwarding:
  - Stimulus: queue holds rd=3/0xA then rd=3/0xB; query fwd_addr_i=3.
  - Required response: hit=1 with data=0xB.
  - Query fwd_addr_i=0 -> hit=0.
REQ-039 Scenario, pause and wrap: run 10 back-to-back pushes with continuous pop (pointer wrap), toggling rdy_in=0 for 2 cycles mid-stream -> no pulses while paused, no loss, no duplicates, and order preserved.
REQ-040 Scenario, reset mid-stream: assert rst_in with count_o=3 -> next cycle count_o=0 and rd_write_o=0; none of the pre-reset entries ever appear on rd_*_o.

Source files
------------

// File: rtl/stage_wb_queue.sv
// stage_wb_queue: in-order writeback FIFO (in_* request side, rd_*_o registered write port, fwd_* youngest-match forwarding, count_o occupancy)
module stage_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  input  logic                         rd_write_i,
  input  logic [DATA_W-1:0]            rd_data_i,
  input  logic                         wr_ready_i,
  output logic [ADDR_W-1:0]            rd_addr_o,
  output logic                         rd_write_o,
  output logic [DATA_W-1:0]            rd_data_o,
  input  logic [ADDR_W-1:0]            fwd_addr_i,
  output logic                         fwd_hit_o,
  output logic [DATA_W-1:0]            fwd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count;
  logic push, pop;
  assign count_o    = count;
  assign in_ready_o = (count < CW'(DEPTH)) && rdy_in && !rst_in;
  assign push       = in_valid_i && in_ready_o && rd_write_i && (rd_addr_i != '0);
  assign pop        = rdy_in && wr_ready_i && (count != '0);
  always_ff @(posedge clk_in) begin
    if (push) begin
      addr_q[tail] <= rd_addr_i;
      data_q[tail] <= rd_data_i;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      rd_write_o <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
    end else begin
      rd_write_o <= pop;
      count      <= count + CW'(push) - CW'(pop);
      if (push) tail <= tail + PW'(1);
      if (pop) begin
        head      <= head + PW'(1);
        rd_addr_o <= addr_q[head];
        rd_data_o <= data_q[head];
      end
    end
  end
  // Scan oldest to youngest so the youngest matching entry wins; the output register sits below all entries.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    idx        = '0;
    if (!rst_in && fwd_addr_i != '0) begin
      if (rd_write_o && rd_addr_o == fwd_addr_i) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = rd_data_o;
      end
      for (int i = DEPTH-1; i >= 0; i--) begin
        idx = tail - PW'(i) - PW'(1);
        if (CW'(i) < count && addr_q[idx] == fwd_addr_i) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = data_q[idx];
        end
      end
    end
  end
endmodule
